apb_master_bridge: RTL and testbench

APB initiator bridge. It converts a simple valid/ready command interface into APB setup and access phases, waits for PREADY, and returns a registered one-cycle response. It sits between the bench or internal controller and the APB register-file slave, replacing hand-driven PSELx/PENABLE sequencing. Optionally, it aborts stalled transfers after a bounded wait.

---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_timeout_counter.sv | 35 +++
 rtl/apb_master_bridge.sv | 154 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator bridge.
//   apb_state_e : bridge FSM states
//   APB_*_WIDTH : default address/data widths
//   apb_rsp_t   : completion record (read data + error flag), also used by
//                 sequence/monitor code that collects bridge responses
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// Wait-state counter for stalled APB ACCESS phases.
// Ports:
//   PCLK, PRESETn : clock, async active-low reset
//   clear         : zero the count (asserted on the edge that enters ACCESS)
//   enable        : ACCESS cycle with PREADY low; counts one per edge
//   limit         : number of stalled ACCESS cycles allowed
//   expired       : this enabled edge is the limit-th stalled cycle
module apb_timeout_counter #(
  parameter int WIDTH = 5
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // count holds the number of stalled edges already seen, so the limit-th
  // one is recognised while count is still limit-1.
  assign expired = enable && (count == (limit - WIDTH'(1)));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator bridge: turns a valid/ready command into APB SETUP/ACCESS
// phases and returns a registered one-cycle response.
// Optional feature macro: APB_TIMEOUT_EN (abort ACCESS after TIMEOUT_CYCLES
// stalled cycles with rsp_err=1). Without it ACCESS waits forever and
// rsp_err stays 0.
// Ports:
//   PCLK, PRESETn                       : clock, async active-low reset
//   cmd_valid/cmd_ready                 : command handshake (ready only in IDLE)
//   cmd_write, cmd_addr, cmd_wdata      : command payload
//   rsp_valid, rsp_rdata, rsp_err       : one-cycle completion, no backpressure
//   PADDR, PWRITE, PWDATA, PSELx, PENABLE : APB request
//   PREADY, PRDATA                      : APB slave response
//
// state  | meaning
// IDLE   | no transfer; cmd_ready high, accepts a command
// SETUP  | PSELx=1, PENABLE=0 for one cycle
// ACCESS | PSELx=1, PENABLE=1 until PREADY (or timeout)
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PSELx,
  output logic                  PENABLE,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_e            state, state_next;
  logic [ADDR_WIDTH-1:0] paddr_next;
  logic                  pwrite_next;
  logic [DATA_WIDTH-1:0] pwdata_next;
  logic                  psel_next;
  logic                  penable_next;
  logic                  rsp_valid_next;
  logic [DATA_WIDTH-1:0] rsp_rdata_next;
  logic                  rsp_err_next;
  logic                  timeout_hit;

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  apb_timeout_counter #(
    .WIDTH(TW)
  ) u_timeout (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (state == SETUP),
    .enable  ((state == ACCESS) && !PREADY),
    .limit   (TW'(TIMEOUT_CYCLES)),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next     = state;
    paddr_next     = PADDR;
    pwrite_next    = PWRITE;
    pwdata_next    = PWDATA;
    psel_next      = PSELx;
    penable_next   = PENABLE;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata;
    rsp_err_next   = rsp_err;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_next   = SETUP;
          paddr_next   = cmd_addr;
          pwrite_next  = cmd_write;
          pwdata_next  = cmd_wdata;
          psel_next    = 1'b1;
          penable_next = 1'b0;
        end
      end
      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
      end
      ACCESS: begin
        // PREADY wins over a timeout landing on the same edge.
        if (PREADY) begin
          state_next     = IDLE;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b0;
          rsp_rdata_next = PWRITE ? '0 : PRDATA;
        end else if (timeout_hit) begin
          state_next     = IDLE;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = '0;
        end
      end
      default: begin
        state_next   = IDLE;
        psel_next    = 1'b0;
        penable_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_ready <= (state_next == IDLE);
      PADDR     <= paddr_next;
      PWRITE    <= pwrite_next;
      PWDATA    <= pwdata_next;
      PSELx     <= psel_next;
      PENABLE   <= penable_next;
      rsp_valid <= rsp_valid_next;
      rsp_rdata <= rsp_rdata_next;
      rsp_err   <= rsp_err_next;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
`timescale 1ns/1ps
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PSELx;
  logic          PENABLE;
  logic          PREADY = 1'b0;
  logic [DW-1:0] PRDATA = '0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSELx(PSELx),
    .PENABLE(PENABLE), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Slave register file (written only through APB) and reference memory
  // (written by the bench when it issues a write that must complete).
  logic [31:0] slave_mem [0:63];
  logic [31:0] model_mem [0:63];
  int slave_waits = 0;
  int acc_cnt = 0;

  always @(negedge PCLK) begin
    if (PSELx && PENABLE) begin
      PREADY  = (acc_cnt >= slave_waits);
      PRDATA  = PWRITE ? $urandom : slave_mem[PADDR[7:2]];
      acc_cnt = acc_cnt + 1;
    end else begin
      PREADY  = 1'($urandom_range(0, 1));
      PRDATA  = $urandom;
      acc_cnt = 0;
    end
  end

  always @(posedge PCLK)
    if (PRESETn && PSELx && PENABLE && PREADY && PWRITE)
      slave_mem[PADDR[7:2]] <= PWDATA;

  typedef struct {
    int       lat;
    int       pen;
    bit       setup_ok;
    bit       stable;
    bit       idle_at_rsp;
    bit       pulse_ok;
    bit       hold_ok;
    apb_rsp_t rsp;
  } obs_t;

  // Issue one command and observe it; lat counts cycles after the accept edge.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, output obs_t o);
    int guard;
    o.lat = 0; o.pen = 0; o.setup_ok = 0; o.stable = 0;
    o.idle_at_rsp = 0; o.pulse_ok = 0; o.hold_ok = 0; o.rsp = '0;
    slave_waits = waits;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge PCLK);
      guard++;
    end
    n_checks++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL accept_wait: cmd_ready=0 after %0d cycles, required 1", guard);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
    o.setup_ok = PSELx && !PENABLE;
    o.stable = 1; o.lat = 1;
    while (!rsp_valid && o.lat < 200) begin
      if (PSELx && (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata)) o.stable = 0;
      if (PENABLE) o.pen++;
      @(negedge PCLK);
      o.lat++;
    end
    n_checks++;
    if (!rsp_valid) begin
      n_fail++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles, required 1", o.lat);
      return;
    end
    o.idle_at_rsp = !PSELx && !PENABLE;
    o.rsp.rdata = rsp_rdata;
    o.rsp.err   = rsp_err;
    @(negedge PCLK);
    o.pulse_ok = !rsp_valid;
    o.hold_ok  = (rsp_rdata === o.rsp.rdata) && (rsp_err === o.rsp.err);
  endtask

  task automatic test_reset();
    #2 PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    #1;
    n_checks++;
    if ({PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: sel/en/wr/rv/err/rdy=%b, required 000000",
               {PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready});
    end
    n_checks++;
    if (PADDR !== '0 || PWDATA !== '0 || rsp_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h, required 0", PADDR, PWDATA, rsp_rdata);
    end
    PRESETn = 1'b1;
    @(negedge PCLK);
    n_checks++;
    if (cmd_ready !== 1'b1 || PSELx !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b sel=%b rv=%b, required 1 0 0", cmd_ready, PSELx, rsp_valid);
    end
  endtask

  task automatic test_write();
    obs_t o;
    run_cmd(1'b1, 32'h04, 32'hDEADBEEF, 0, o);
    model_mem[1] = 32'hDEADBEEF;
    n_checks++;
    if (o.lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d, required 3", o.lat); end
    n_checks++;
    if (o.pen !== 1) begin n_fail++; $display("FAIL wr_access_cycles: got %0d, required 1", o.pen); end
    n_checks++;
    if (!o.setup_ok) begin n_fail++; $display("FAIL wr_setup: got bad SETUP, required PSELx=1 PENABLE=0"); end
    n_checks++;
    if (!o.stable) begin n_fail++; $display("FAIL wr_stable: got changing PADDR/PWRITE/PWDATA, required stable"); end
    n_checks++;
    if (!o.idle_at_rsp) begin n_fail++; $display("FAIL wr_idle: got PSELx/PENABLE high at rsp, required 0"); end
    n_checks++;
    if (o.rsp !== '{rdata: 32'h0, err: 1'b0}) begin
      n_fail++; $display("FAIL wr_rsp: got rdata=%h err=%b, required 0 0", o.rsp.rdata, o.rsp.err);
    end
    n_checks++;
    if (!o.pulse_ok) begin n_fail++; $display("FAIL wr_pulse: got rsp_valid=1 next cycle, required 0"); end
    n_checks++;
    if (slave_mem[1] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_slave_mem: got %h, required deadbeef", slave_mem[1]);
    end
  endtask

  task automatic test_read_wait();
    obs_t o;
    run_cmd(1'b0, 32'h04, $urandom, 2, o);
    n_checks++;
    if (o.pen !== 3) begin n_fail++; $display("FAIL rd_access_cycles: got %0d, required 3", o.pen); end
    n_checks++;
    if (o.lat !== 5) begin n_fail++; $display("FAIL rd_latency: got %0d, required 5", o.lat); end
    n_checks++;
    if (!o.stable) begin n_fail++; $display("FAIL rd_stable: got changing PADDR, required stable"); end
    n_checks++;
    if (o.rsp.rdata !== model_mem[1] || o.rsp.err !== 1'b0) begin
      n_fail++; $display("FAIL rd_rsp: got rdata=%h err=%b, required %h 0", o.rsp.rdata, o.rsp.err, model_mem[1]);
    end
    n_checks++;
    if (!o.pulse_ok || !o.hold_ok) begin
      n_fail++; $display("FAIL rd_pulse_hold: got pulse_ok=%b hold_ok=%b, required 1 1", o.pulse_ok, o.hold_ok);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4] = '{32'h00, 32'h08, 32'h0C, 32'h10};
    logic [31:0] dat [4];
    int acc_cyc[$];
    int rsp_cyc[$];
    bit psel_tr[$];
    int idx = 0;
    int zeros = 0;
    bit acc;
    obs_t o;
    for (int k = 0; k < 4; k++) dat[k] = $urandom;
    slave_waits = 0;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addrs[0]; cmd_wdata = dat[0];
    for (int c = 0; c < 30; c++) begin
      psel_tr.push_back(PSELx);
      if (rsp_valid) rsp_cyc.push_back(c);
      acc = cmd_ready && cmd_valid;
      if (acc) acc_cyc.push_back(c);
      @(negedge PCLK);
      if (acc) begin
        idx++;
        if (idx < 4) begin cmd_addr = addrs[idx]; cmd_wdata = dat[idx]; end
        else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 4; k++) model_mem[addrs[k][7:2]] = dat[k];
    n_checks++;
    if (acc_cyc.size() !== 4 || rsp_cyc.size() !== 4) begin
      n_fail++; $display("FAIL b2b_counts: got %0d accepts %0d rsps, required 4 4", acc_cyc.size(), rsp_cyc.size());
    end
    for (int k = 0; k < acc_cyc.size() && k < rsp_cyc.size(); k++) begin
      n_checks++;
      if (rsp_cyc[k] !== acc_cyc[k] + 3) begin
        n_fail++; $display("FAIL b2b_rsp_order[%0d]: got cycle %0d, required %0d", k, rsp_cyc[k], acc_cyc[k] + 3);
      end
      if (k > 0) begin
        n_checks++;
        if (acc_cyc[k] - acc_cyc[k-1] !== 3) begin
          n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d, required 3", k, acc_cyc[k] - acc_cyc[k-1]);
        end
      end
    end
    if (acc_cyc.size() == 4) begin
      for (int c = acc_cyc[0] + 1; c <= acc_cyc[3]; c++) if (!psel_tr[c]) zeros++;
      n_checks++;
      if (zeros !== 3) begin n_fail++; $display("FAIL b2b_idle_gaps: got %0d idle cycles, required 3", zeros); end
    end
    for (int k = 0; k < 4; k++) begin
      run_cmd(1'b0, addrs[k], $urandom, $urandom_range(0, 2), o);
      n_checks++;
      if (o.rsp.rdata !== dat[k] || o.rsp.err !== 1'b0) begin
        n_fail++; $display("FAIL b2b_readback[%0d]: got %h err=%b, required %h 0", k, o.rsp.rdata, o.rsp.err, dat[k]);
      end
    end
  endtask

  task automatic test_stall();
    obs_t o;
`ifdef APB_TIMEOUT_EN
    // PREADY arriving on the limit-th stalled edge still completes normally.
    run_cmd(1'b0, 32'h04, $urandom, TO - 1, o);
    n_checks++;
    if (o.lat !== TO + 2 || o.rsp.err !== 1'b0 || o.rsp.rdata !== model_mem[1]) begin
      n_fail++; $display("FAIL to_boundary: got lat=%0d err=%b rdata=%h, required %0d 0 %h",
                         o.lat, o.rsp.err, o.rsp.rdata, TO + 2, model_mem[1]);
    end
    run_cmd(1'b0, 32'h04, $urandom, 1000, o);
    n_checks++;
    if (o.pen !== TO || o.lat !== TO + 2) begin
      n_fail++; $display("FAIL to_abort_time: got pen=%0d lat=%0d, required %0d %0d", o.pen, o.lat, TO, TO + 2);
    end
    n_checks++;
    if (o.rsp.err !== 1'b1 || o.rsp.rdata !== 32'h0) begin
      n_fail++; $display("FAIL to_abort_rsp: got err=%b rdata=%h, required 1 0", o.rsp.err, o.rsp.rdata);
    end
    n_checks++;
    if (!o.idle_at_rsp || !o.pulse_ok) begin
      n_fail++; $display("FAIL to_abort_idle: got idle=%b pulse=%b, required 1 1", o.idle_at_rsp, o.pulse_ok);
    end
    run_cmd(1'b1, 32'h14, 32'hA5A5_0001, 0, o);
    model_mem[5] = 32'hA5A5_0001;
    n_checks++;
    if (o.lat !== 3 || o.rsp.err !== 1'b0) begin
      n_fail++; $display("FAIL to_recover: got lat=%0d err=%b, required 3 0", o.lat, o.rsp.err);
    end
`else
    // Without the timeout a long stall simply waits.
    run_cmd(1'b0, 32'h04, $urandom, 40, o);
    n_checks++;
    if (o.pen !== 41 || o.lat !== 43) begin
      n_fail++; $display("FAIL stall_wait: got pen=%0d lat=%0d, required 41 43", o.pen, o.lat);
    end
    n_checks++;
    if (o.rsp.err !== 1'b0 || o.rsp.rdata !== model_mem[1]) begin
      n_fail++; $display("FAIL stall_rsp: got err=%b rdata=%h, required 0 %h", o.rsp.err, o.rsp.rdata, model_mem[1]);
    end
`endif
  endtask

  task automatic test_reset_abort();
    int guard = 0;
    bit saw_rsp = 0;
    obs_t o;
    slave_waits = 1000;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h08; cmd_wdata = 32'h1234_5678;
    while (!cmd_ready && guard < 50) begin @(negedge PCLK); guard++; end
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    n_checks++;
    if (PENABLE !== 1'b1 || PSELx !== 1'b1) begin
      n_fail++; $display("FAIL ra_in_access: got sel=%b en=%b, required 1 1", PSELx, PENABLE);
    end
    #2 PRESETn = 1'b0;
    #1;
    n_checks++;
    if ({PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready} !== 6'b0 || PADDR !== '0 || PWDATA !== '0) begin
      n_fail++; $display("FAIL ra_async_drop: sel/en/wr/rv/err/rdy=%b paddr=%h, required 000000 0",
                         {PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready}, PADDR);
    end
    repeat (3) begin @(negedge PCLK); if (rsp_valid) saw_rsp = 1; end
    PRESETn = 1'b1;
    slave_waits = 0;
    repeat (2) begin @(negedge PCLK); if (rsp_valid) saw_rsp = 1; end
    n_checks++;
    if (saw_rsp) begin n_fail++; $display("FAIL ra_no_rsp: got rsp_valid=1, required 0"); end
    run_cmd(1'b0, 32'h08, $urandom, 1, o);
    n_checks++;
    if (o.rsp.rdata !== model_mem[2] || o.rsp.err !== 1'b0 || o.lat !== 4) begin
      n_fail++; $display("FAIL ra_read_after: got rdata=%h err=%b lat=%0d, required %h 0 4",
                         o.rsp.rdata, o.rsp.err, o.lat, model_mem[2]);
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit wr;
    logic [31:0] addr, data, exp;
    int w;
    for (int t = 0; t < 24; t++) begin
      wr = 1'($urandom_range(0, 1));
      addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      data = $urandom;
      w = $urandom_range(0, 3);
      exp = wr ? 32'h0 : model_mem[addr[7:2]];
      run_cmd(wr, addr, data, w, o);
      if (wr) model_mem[addr[7:2]] = data;
      n_checks++;
      if (o.lat !== 3 + w || o.pen !== 1 + w) begin
        n_fail++; $display("FAIL rnd_timing[%0d]: got lat=%0d pen=%0d, required %0d %0d", t, o.lat, o.pen, 3 + w, 1 + w);
      end
      n_checks++;
      if (o.rsp.rdata !== exp || o.rsp.err !== 1'b0) begin
        n_fail++; $display("FAIL rnd_rsp[%0d]: got rdata=%h err=%b, required %h 0", t, o.rsp.rdata, o.rsp.err, exp);
      end
      n_checks++;
      if (!o.stable || !o.setup_ok || !o.pulse_ok) begin
        n_fail++; $display("FAIL rnd_protocol[%0d]: got stable=%b setup=%b pulse=%b, required 1 1 1",
                           t, o.stable, o.setup_ok, o.pulse_ok);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin slave_mem[i] = '0; model_mem[i] = '0; end
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_stall();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
